seg_bcd_conv: RTL and testbench

//  Sequential binary-to-packed-BCD converter (shift-add-3 / double dabble).

---
 rtl/seg_bcd_conv.sv | 131 +++++++++++++
 tb/tb_seg_bcd_conv.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_conv.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), start/busy/done handshake.
// Inputs above 10^DIGITS-1 saturate to all nines and raise ovf.
module seg_bcd_conv #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int CMP_W = (IN_W > 32) ? IN_W : 32;

    function automatic logic [CMP_W-1:0] max_bcd_val(input int n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < n; i++) p = p * CMP_W'(10);
        return p - CMP_W'(1);
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = max_bcd_val(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]  scr_q, scr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  scr_sh;
    logic [IN_W-1:0]   bin_sh;
    logic              sat;

    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
        // Top scratch bit is always zero here because the input is saturated.
        scr_sh = {adj[BCD_W-2:0], bin_q[IN_W-1]};
        bin_sh = {bin_q[IN_W-2:0], 1'b0};
        sat    = (CMP_W'(bin_in) > MAX_VAL);
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = sat ? IN_W'(MAX_VAL) : bin_in;
                    pend_d  = sat;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = scr_sh;
                bin_d = bin_sh;
                cnt_d = cnt_q + CNT_W'(1);
                // Result is registered on the final shift so it appears alongside done.
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    bcd_d   = scr_sh;
                    ovf_d   = pend_q;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seg_bcd_conv.sv
// Directed bench for seg_bcd_conv: timing, saturation, back-to-back, mid-conversion reset.
module tb_seg_bcd_conv;

    logic        clk;
    logic        rst;
    logic [15:0] bin_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int pass_cnt = 0;
    int total    = 0;

    seg_bcd_conv #(.IN_W(16), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_bcd(input int x);
        int m;
        m = (x > 9999) ? 9999 : x;
        return {4'((m / 1000) % 10), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Called at a negedge; returns at the negedge of the first idle cycle after done.
    task automatic do_conv(input logic [15:0] v, output logic [15:0] res,
                           output logic o, output int lat);
        int n;
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = (done === 1'b1) ? n : 99;
        res = bcd_out;
        o   = ovf;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin_in = 16'd0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        total++;
        if (bcd_out !== 16'h0 || ovf !== 1'b0) $display("FAIL reset_data bcd=%h ovf=%b want 0000 0", bcd_out, ovf);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_busy, exp_done;
        bin_in = 16'd1234;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            exp_busy = (k <= 17);
            exp_done = (k == 17);
            total++;
            if (busy !== exp_busy) $display("FAIL basic_busy cyc=T+%0d busy=%b want %b", k, busy, exp_busy);
            else pass_cnt++;
            total++;
            if (done !== exp_done) $display("FAIL basic_done cyc=T+%0d done=%b want %b", k, done, exp_done);
            else pass_cnt++;
            if (k == 17) begin
                total++;
                if (bcd_out !== 16'h1234 || ovf !== 1'b0)
                    $display("FAIL basic_result bcd=%h ovf=%b want 1234 0", bcd_out, ovf);
                else pass_cnt++;
            end
            if (k < 18) @(negedge clk);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] vals [5] = '{16'd0, 16'd9999, 16'd10000, 16'd65535, 16'd42};
        logic [15:0] exp_b [5] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999, 16'h0042};
        logic        exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] res;
        logic        o;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_conv(vals[i], res, o, lat);
            total++;
            if (res !== exp_b[i] || o !== exp_o[i] || lat != 17)
                $display("FAIL bound_%0d in=%0d bcd=%h ovf=%b lat=%0d want %h %b 17",
                         i, vals[i], res, o, lat, exp_b[i], exp_o[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        bin_in = 16'd7;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 36; k++) begin
            if (k == 5) bin_in = 16'd8;
            exp_busy = (k <= 17) || (k >= 19 && k <= 35);
            exp_done = (k == 17) || (k == 35);
            total++;
            if (busy !== exp_busy || done !== exp_done)
                $display("FAIL b2b_ctrl cyc=T+%0d busy=%b done=%b want %b %b", k, busy, done, exp_busy, exp_done);
            else pass_cnt++;
            if (k == 17) begin
                total++;
                if (bcd_out !== 16'h0007) $display("FAIL b2b_first bcd=%h want 0007", bcd_out);
                else pass_cnt++;
            end
            if (k == 35) begin
                total++;
                if (bcd_out !== 16'h0008) $display("FAIL b2b_second bcd=%h want 0008", bcd_out);
                else pass_cnt++;
            end
            if (k == 19) start = 1'b0;
            if (k < 36) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        logic        o;
        int          lat;
        int          dones;
        bin_in = 16'd5678;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0 || ovf !== 1'b0)
            $display("FAIL midrst_clear busy=%b done=%b bcd=%h ovf=%b want 0 0 0000 0", busy, done, bcd_out, ovf);
        else pass_cnt++;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) $display("FAIL midrst_nodone pulses=%0d want 0", dones);
        else pass_cnt++;
        do_conv(16'd5678, res, o, lat);
        total++;
        if (res !== 16'h5678 || o !== 1'b0 || lat != 17)
            $display("FAIL midrst_fresh bcd=%h ovf=%b lat=%0d want 5678 0 17", res, o, lat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] v, res, exp;
        logic        o;
        int          lat;
        logic        bad_nib;
        for (int i = 0; i < 20; i++) begin
            v = 16'($urandom_range(0, 65535));
            exp = ref_bcd(int'(v));
            do_conv(v, res, o, lat);
            total++;
            if (res !== exp || o !== (v > 16'd9999) || lat != 17)
                $display("FAIL rand_%0d in=%0d bcd=%h ovf=%b lat=%0d want %h %b 17",
                         i, v, res, o, lat, exp, (v > 16'd9999));
            else pass_cnt++;
            bad_nib = 1'b0;
            for (int d = 0; d < 4; d++) if (res[4*d +: 4] > 4'd9) bad_nib = 1'b1;
            total++;
            if (bad_nib !== 1'b0) $display("FAIL rand_nibble_%0d bcd=%h has digit > 9", i, res);
            else pass_cnt++;
            total++;
            if (done !== 1'b0) $display("FAIL rand_single_done_%0d done=%b want 0 after pulse", i, done);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bin_in = 16'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
